dmem_stage: RTL and testbench
=============================

Name: dmem_stage

Overview:
- Memory-access (M) stage of the 5-stage RV32I pipeline, directly downstream of the execute/forwarding datapath.
- Takes the registered ALU result (address), the forwarded rs2 store data and the M-stage instruction word.
- Performs byte/half/word stores into an internal word-organised RAM and returns load data, combinationally and sign/zero-extended, to the write-back mux in the same cycle.
- Also flags misaligned accesses and, optionally, exposes a small memory-mapped I/O window.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two
ADDR_W, 10, word-index width; must equal log2(DEPTH_WORDS)

Ports:
dp_clk  in  1  pipeline clock, rising edge
dp_rst  in  1  reset, synchronous, active-low
mem_inst  in  32  instruction currently in M stage (opcode [6:0], funct3 [14:12])
mem_addr  in  32  byte address (registered ALU result)
mem_wdata  in  32  store data (registered forwarded rs2)
mem_rdata  out  32  extended load data to write-back mux; combinational
misalign_flag  out  1  sticky misaligned-access indicator
misalign_addr  out  32  address of first misaligned access
gpio_out  out  32  MMIO GPIO register (0 when DMEM_MMIO_EN undefined)

Behaviour:
- Decode:
  - load = opcode 7'b0000011; store = opcode 7'b0100011; anything else is a no-op.
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Other load funct3 values return 0.
  - Store funct3: 000 SB, 001 SH, 010 SW. Other store funct3 values write nothing.
- Addressing:
  - Word index = mem_addr[ADDR_W+1:2]; upper bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
  - Lane = mem_addr[1:0]; little-endian byte order.
- Stores:
  - Byte enables: SB 4'b0001<<lane; SH 4'b0011<<lane; SW 4'b1111.
  - Store data is replicated into the selected lanes (byte in all 4 lanes, half in both halves).
  - The write commits at the dp_clk rising edge that ends the M cycle.
  - No write on any edge where dp_rst==0.
- Loads:
  - Read is asynchronous: mem_rdata is valid in the same cycle as mem_addr.
  - Selected lane(s) are sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - A load in cycle N+1 sees a store committed at the end of cycle N (no internal bypass needed; load and store never coexist in M).
- Non-memory instruction: mem_rdata = 32'h0; no write.
- Misaligned access:
  - Definition: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Effect: the store is suppressed; the load returns 32'h0.
  - misalign_flag sets at the next edge and stays set until reset.
  - misalign_addr captures mem_addr only on the first occurrence (flag was 0).
- Reset (dp_rst==0 at an edge):
  - misalign_flag=0, misalign_addr=0, gpio_out=0, cycle counter=0.
  - RAM contents are NOT cleared.
  - A store present during that edge is dropped.
- No stall/handshake: the stage always completes in one cycle; latency 0 for loads, 1 edge for stores.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- When defined:
  - Decode is on the full 32-bit mem_addr.
  - 0xFFFF_FF00 is GPIO (R/W, byte-enable honoured, drives gpio_out, reset 0).
  - 0xFFFF_FF04 is CYCLE: a free-running 32-bit counter. It increments every edge with dp_rst==1, wraps 0xFFFF_FFFF->0, is read-only, and stores to it are ignored.
  - Loads return the pre-edge register value with the normal lane extension.
  - MMIO accesses never touch RAM.
  - Misalignment rules apply unchanged.
- When undefined:
  - No GPIO or counter logic exists; gpio_out is tied to 0.
  - Those addresses alias into RAM via the normal wrap.

Test Plan:
- Word: SW addr 0x10 data 0xDEADBEEF, next cycle LW 0x10 -> mem_rdata 0xDEADBEEF.
- Sub-word:
  - SB 0x13 data 0x000000A5 after the above.
  - LW 0x10 -> 0xA5ADBEEF.
  - LB 0x13 -> 0xFFFFFFA5.
  - LBU 0x13 -> 0x000000A5.
  - LH 0x12 -> 0xFFFFA5AD.
  - LHU 0x12 -> 0x0000A5AD.
- Misaligned:
  - SW 0x21 data 0x12345678 -> no RAM change; LW 0x20 returns the prior value.
  - misalign_flag=1 and misalign_addr=0x21 after the edge.
  - A later LH 0x23 leaves misalign_addr at 0x21.
- Wrap (DEPTH_WORDS=1024): SW 0x1000 data 0x55AA55AA -> LW 0x0 returns 0x55AA55AA.
- Reset:
  - Assert dp_rst=0 for one edge while a SW 0x40 data 0x1 is present.
  - Result: flag/addr/gpio cleared; LW 0x40 returns its pre-reset contents.
  - Earlier RAM words are retained.
- MMIO (DMEM_MMIO_EN):
  - SW 0xFFFFFF00 data 0x0000_00F0 -> gpio_out 0xF0.
  - SB 0xFFFFFF01 data 0x3C -> gpio_out 0x3CF0.
  - Two LW 0xFFFFFF04 loads k cycles apart after reset differ by k.
  - SW 0xFFFFFF04 is ignored.

Source files
------------

// File: rtl/dmem_stage.sv
// dmem_stage: memory-access stage of the RV32I pipeline.
// Byte/half/word stores into a word-organised RAM, combinational
// sign/zero-extended loads, and sticky misaligned-access capture.
// Optional MMIO window (GPIO at 0xFFFF_FF00, free-running CYCLE at
// 0xFFFF_FF04) is compiled in when DMEM_MMIO_EN is defined.
module dmem_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic        dp_clk,
    input  logic        dp_rst,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        misalign_flag,
    output logic [31:0] misalign_addr,
    output logic [31:0] gpio_out
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    logic [31:0] ram [0:DEPTH_WORDS-1];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_load;
    logic              is_store;
    size_e             acc_size;
    logic              ld_unsigned;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_idx;
    logic              misalign;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep;
    logic              ram_sel;
    logic              ram_we;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;

`ifdef DMEM_MMIO_EN
    logic        sel_gpio;
    logic        sel_cycle;
    logic [31:0] gpio_q;
    logic [31:0] cycle_q;
    logic        unused_inst;

    assign unused_inst = ^{mem_inst[31:15], mem_inst[11:7]};
`else
    logic        unused_bits;

    assign unused_bits = ^{mem_inst[31:15], mem_inst[11:7], mem_addr[31:ADDR_W+2]};
`endif

    assign opcode   = mem_inst[6:0];
    assign funct3   = mem_inst[14:12];
    assign lane     = mem_addr[1:0];
    assign word_idx = mem_addr[ADDR_W+1:2];

    // Instruction decode: access size, signedness, and lane enables.
    always_comb begin
        is_load     = (opcode == OP_LOAD);
        is_store    = (opcode == OP_STORE);
        acc_size    = SZ_NONE;
        ld_unsigned = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000:  acc_size = SZ_BYTE;
                3'b001:  acc_size = SZ_HALF;
                3'b010:  acc_size = SZ_WORD;
                3'b100: begin
                    acc_size    = SZ_BYTE;
                    ld_unsigned = 1'b1;
                end
                3'b101: begin
                    acc_size    = SZ_HALF;
                    ld_unsigned = 1'b1;
                end
                default: acc_size = SZ_NONE;
            endcase
        end else if (is_store) begin
            case (funct3)
                3'b000:  acc_size = SZ_BYTE;
                3'b001:  acc_size = SZ_HALF;
                3'b010:  acc_size = SZ_WORD;
                default: acc_size = SZ_NONE;
            endcase
        end

        misalign = ((acc_size == SZ_HALF) && lane[0]) ||
                   ((acc_size == SZ_WORD) && (lane != 2'b00));

        byte_en   = 4'b0000;
        wdata_rep = mem_wdata;
        case (acc_size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{mem_wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en   = 4'b0011 << lane;
                wdata_rep = {2{mem_wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en   = 4'b1111;
                wdata_rep = mem_wdata;
            end
            default: byte_en = 4'b0000;
        endcase
    end

`ifdef DMEM_MMIO_EN
    assign sel_gpio  = (mem_addr[31:2] == 30'h3FFF_FFC0);
    assign sel_cycle = (mem_addr[31:2] == 30'h3FFF_FFC1);
    assign ram_sel   = !(sel_gpio || sel_cycle);
`else
    assign ram_sel   = 1'b1;
`endif

    // Stores are dropped while in reset, when misaligned, or when aimed at MMIO.
    assign ram_we = dp_rst && is_store && (acc_size != SZ_NONE) && !misalign && ram_sel;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge dp_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && byte_en[b]) begin
                ram[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_EN
    // GPIO register: byte-enable writes, cleared by reset.
    always_ff @(posedge dp_clk) begin
        if (!dp_rst) begin
            gpio_q <= 32'h0;
        end else if (is_store && (acc_size != SZ_NONE) && !misalign && sel_gpio) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    gpio_q[8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Free-running cycle counter; read-only, wraps naturally.
    always_ff @(posedge dp_clk) begin
        if (!dp_rst) begin
            cycle_q <= 32'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign gpio_out = gpio_q;
    assign rd_word  = sel_gpio  ? gpio_q  :
                      sel_cycle ? cycle_q : ram[word_idx];
`else
    assign gpio_out = 32'h0;
    assign rd_word  = ram[word_idx];
`endif

    assign rd_shift = rd_word >> {lane, 3'b000};

    // Load data extraction and extension; misaligned or invalid loads return 0.
    always_comb begin
        mem_rdata = 32'h0;
        if (is_load && !misalign) begin
            case (acc_size)
                SZ_BYTE: mem_rdata = ld_unsigned ? {24'h0, rd_shift[7:0]}
                                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
                SZ_HALF: mem_rdata = ld_unsigned ? {16'h0, rd_shift[15:0]}
                                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
                SZ_WORD: mem_rdata = rd_word;
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    // Sticky misalignment flag; address latched on the first offence only.
    always_ff @(posedge dp_clk) begin
        if (!dp_rst) begin
            misalign_flag <= 1'b0;
            misalign_addr <= 32'h0;
        end else if ((is_load || is_store) && misalign) begin
            misalign_flag <= 1'b1;
            if (!misalign_flag) begin
                misalign_addr <= mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed vectors for dmem_stage with hand-computed results.
// Build with +define+DMEM_MMIO_EN to exercise the MMIO window.
module tb_dmem_stage;

    logic        dp_clk;
    logic        dp_rst;
    logic [31:0] mem_inst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        misalign_flag;
    logic [31:0] misalign_addr;
    logic [31:0] gpio_out;

    int n_vec;
    int n_err;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_AL = 7'b0110011;

    dmem_stage #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
        .dp_clk        (dp_clk),
        .dp_rst        (dp_rst),
        .mem_inst      (mem_inst),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .misalign_flag (misalign_flag),
        .misalign_addr (misalign_addr),
        .gpio_out      (gpio_out)
    );

    initial dp_clk = 1'b0;
    always #5 dp_clk = ~dp_clk;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        mem_inst  = {17'h0, f3, 5'h0, op};
        mem_addr  = addr;
        mem_wdata = wdata;
        #1;
    endtask

    task automatic step();
        @(posedge dp_clk);
        #1;
    endtask

    task automatic nop();
        drive(OP_AL, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;
        n_vec = 0;
        n_err = 0;
        dp_rst = 1'b0;
        mem_inst = 32'h0;
        mem_addr = 32'h0;
        mem_wdata = 32'h0;
        @(negedge dp_clk);
        nop();
        step();
        step();
        chk("rst_flag", {31'h0, misalign_flag}, 32'h0);
        chk("rst_maddr", misalign_addr, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        dp_rst = 1'b1;
        nop();
        chk("nop_rdata", mem_rdata, 32'h0);
        step();

        // Word store then load
        drive(OP_ST, 3'b010, 32'h10, 32'hDEADBEEF); step();
        drive(OP_LD, 3'b010, 32'h10, 32'h0);
        chk("lw_10", mem_rdata, 32'hDEADBEEF);
        step();

        // Sub-word
        drive(OP_ST, 3'b000, 32'h13, 32'h000000A5); step();
        drive(OP_LD, 3'b010, 32'h10, 32'h0); chk("lw_10_sb", mem_rdata, 32'hA5ADBEEF);
        drive(OP_LD, 3'b000, 32'h13, 32'h0); chk("lb_13", mem_rdata, 32'hFFFFFFA5);
        drive(OP_LD, 3'b100, 32'h13, 32'h0); chk("lbu_13", mem_rdata, 32'h000000A5);
        drive(OP_LD, 3'b001, 32'h12, 32'h0); chk("lh_12", mem_rdata, 32'hFFFFA5AD);
        drive(OP_LD, 3'b101, 32'h12, 32'h0); chk("lhu_12", mem_rdata, 32'h0000A5AD);
        drive(OP_LD, 3'b000, 32'h10, 32'h0); chk("lb_10", mem_rdata, 32'hFFFFFFEF);
        drive(OP_LD, 3'b101, 32'h10, 32'h0); chk("lhu_10", mem_rdata, 32'h0000BEEF);
        drive(OP_LD, 3'b011, 32'h10, 32'h0); chk("ld_bad_f3", mem_rdata, 32'h0);
        step();
        drive(OP_ST, 3'b011, 32'h10, 32'h11111111); step();
        drive(OP_LD, 3'b010, 32'h10, 32'h0); chk("st_bad_f3", mem_rdata, 32'hA5ADBEEF);
        step();

        // Misaligned
        drive(OP_ST, 3'b010, 32'h20, 32'h11112222); step();
        chk("flag_pre", {31'h0, misalign_flag}, 32'h0);
        drive(OP_ST, 3'b010, 32'h21, 32'h12345678);
        chk("flag_before_edge", {31'h0, misalign_flag}, 32'h0);
        step();
        chk("flag_set", {31'h0, misalign_flag}, 32'h1);
        chk("maddr_21", misalign_addr, 32'h21);
        drive(OP_LD, 3'b010, 32'h20, 32'h0); chk("lw_20_kept", mem_rdata, 32'h11112222);
        drive(OP_LD, 3'b010, 32'h21, 32'h0); chk("lw_21_mis", mem_rdata, 32'h0);
        drive(OP_LD, 3'b001, 32'h23, 32'h0); chk("lh_23_mis", mem_rdata, 32'h0);
        step();
        chk("maddr_sticky", misalign_addr, 32'h21);
        chk("flag_sticky", {31'h0, misalign_flag}, 32'h1);
        drive(OP_ST, 3'b001, 32'h22, 32'h0000BEEF); step();
        drive(OP_LD, 3'b010, 32'h20, 32'h0); chk("sh_22", mem_rdata, 32'hBEEF2222);
        step();

        // Address wrap
        drive(OP_ST, 3'b010, 32'h1000, 32'h55AA55AA); step();
        drive(OP_LD, 3'b010, 32'h0, 32'h0); chk("wrap_lw_0", mem_rdata, 32'h55AA55AA);
        step();

        // Reset drops a concurrent store and keeps RAM
        drive(OP_ST, 3'b010, 32'h40, 32'hCAFEF00D); step();
        dp_rst = 1'b0;
        drive(OP_ST, 3'b010, 32'h40, 32'h00000001); step();
        dp_rst = 1'b1;
        nop();
        chk("rst2_flag", {31'h0, misalign_flag}, 32'h0);
        chk("rst2_maddr", misalign_addr, 32'h0);
        chk("rst2_gpio", gpio_out, 32'h0);
        drive(OP_LD, 3'b010, 32'h40, 32'h0); chk("lw_40_kept", mem_rdata, 32'hCAFEF00D);
        drive(OP_LD, 3'b010, 32'h10, 32'h0); chk("lw_10_kept", mem_rdata, 32'hA5ADBEEF);

`ifdef DMEM_MMIO_EN
        drive(OP_LD, 3'b010, 32'hFFFFFF04, 32'h0); c1 = mem_rdata;
        chk("cyc_after_rst", c1, 32'h0);
        for (int i = 0; i < 5; i++) step();
        drive(OP_LD, 3'b010, 32'hFFFFFF04, 32'h0); c2 = mem_rdata;
        chk("cyc_delta5", c2 - c1, 32'd5);
        nop();
        drive(OP_ST, 3'b010, 32'hF00, 32'h13579BDF); step();
        drive(OP_ST, 3'b010, 32'hFFFFFF00, 32'h000000F0); step();
        chk("gpio_sw", gpio_out, 32'h000000F0);
        drive(OP_ST, 3'b000, 32'hFFFFFF01, 32'h0000003C); step();
        chk("gpio_sb", gpio_out, 32'h00003CF0);
        drive(OP_LD, 3'b010, 32'hFFFFFF00, 32'h0); chk("gpio_lw", mem_rdata, 32'h00003CF0);
        drive(OP_LD, 3'b000, 32'hFFFFFF01, 32'h0); chk("gpio_lb", mem_rdata, 32'h0000003C);
        drive(OP_LD, 3'b010, 32'hF00, 32'h0); chk("ram_not_alias", mem_rdata, 32'h13579BDF);
        drive(OP_LD, 3'b010, 32'hFFFFFF04, 32'h0); c1 = mem_rdata;
        drive(OP_ST, 3'b010, 32'hFFFFFF04, 32'hA0000000); step();
        drive(OP_LD, 3'b010, 32'hFFFFFF04, 32'h0);
        chk("cyc_ro", mem_rdata, c1 + 32'd1);
        step();
`else
        drive(OP_ST, 3'b010, 32'hFFFFFF00, 32'h000000F0); step();
        chk("gpio_tied0", gpio_out, 32'h0);
        drive(OP_LD, 3'b010, 32'hF00, 32'h0); chk("mmio_alias", mem_rdata, 32'h000000F0);
        drive(OP_LD, 3'b010, 32'hFFFFFF00, 32'h0); chk("mmio_alias_rd", mem_rdata, 32'h000000F0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
